count_seq_checker: RTL and testbench

Sequence checker that sits on the output side of the 8-bit programmable counter. Each cycle it samples the counter value together with the load/enable controls that produced it, predicts the next value, and compares. It reports lock status, mismatch pulses, a saturating error count and a wrap count. It is used both in the user-project wrapper as a self-test monitor and on the bench as a scoreboard.

---
 rtl/count_seq_checker.sv | 185 ++++++++++++++++++
 tb/tb_count_seq_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// Sequence checker for the 8-bit programmable counter: predicts each value
// from the previous value and controls, reports lock, mismatches and wraps.
//
// Ports:
//   clk         rising-edge clock shared with the counter
//   rst         synchronous active-high reset
//   cnt_in      counter value observed this cycle
//   cnt_en      increment enable applied this cycle
//   cnt_load    load strobe applied this cycle (beats cnt_en)
//   load_val    value applied with cnt_load
//   clear_stats clears err_count and wrap_count at the next edge
//   locked      LOCK_CYCLES consecutive correct predictions seen
//   err         one-cycle pulse on a mismatch while locked
//   err_count   saturating count of mismatches while locked
//   wrap_count  saturating count of predicted all-ones -> 0 wraps
//   expected    prediction compared in the previous cycle
module count_seq_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_en,
  input  logic             cnt_load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear_stats,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACQ   = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  localparam logic [4:0]       LOCK_N = 5'(LOCK_CYCLES);
  localparam logic [ERR_W-1:0] SAT    = '1;
  localparam logic [WIDTH-1:0] ONES   = '1;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] prev_cnt;
  logic [WIDTH-1:0] prev_lv;
  logic             prev_load;
  logic             prev_en;
  logic             hist_valid;

  logic [WIDTH-1:0] pred;
  logic             match;
  logic             miss_locked;
  logic             wrap_hit;

  logic [3:0]       run_cnt;
  logic [3:0]       run_nxt;
  logic [4:0]       run_inc;

  // Counter model: load beats enable, otherwise hold.
  always_comb begin
    pred = prev_cnt;
    if (prev_load) begin
      pred = prev_lv;
    end else if (prev_en) begin
      pred = prev_cnt + 1'b1;
    end
  end

  assign match   = hist_valid && (cnt_in == pred);
  assign run_inc = {1'b0, run_cnt} + 5'd1;

  assign miss_locked = (state == S_LOCK) && hist_valid && !match;

  // Only a correctly predicted increment out of all-ones counts as a wrap.
  assign wrap_hit = (state != S_EMPTY)
                 && prev_en
                 && !prev_load
                 && (prev_cnt == ONES)
                 && match;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and run-length logic.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    unique case (state)
      S_EMPTY: begin
        state_nxt = S_ACQ;
        run_nxt   = 4'd0;
      end
      S_ACQ: begin
        if (match) begin
          run_nxt = run_inc[3:0];
          if (run_inc == LOCK_N) begin
            state_nxt = S_LOCK;
          end
        end else begin
          run_nxt = 4'd0;
        end
      end
      S_LOCK: begin
        if (!match) begin
          run_nxt   = 4'd0;
          state_nxt = S_ACQ;
        end
      end
      default: begin
        state_nxt = S_EMPTY;
        run_nxt   = 4'd0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    locked = 1'b0;
    if (state == S_LOCK) begin
      locked = 1'b1;
    end
  end

  // History is captured every cycle so a mismatch resyncs to cnt_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt   <= '0;
      prev_lv    <= '0;
      prev_load  <= 1'b0;
      prev_en    <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      prev_cnt   <= cnt_in;
      prev_lv    <= load_val;
      prev_load  <= cnt_load;
      prev_en    <= cnt_en;
      hist_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= 4'd0;
      err      <= 1'b0;
      expected <= '0;
    end else begin
      run_cnt  <= run_nxt;
      err      <= miss_locked;
      expected <= pred;
    end
  end

  // clear_stats beats a same-cycle increment; err still pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear_stats) begin
      err_count <= '0;
    end else if (miss_locked && (err_count != SAT)) begin
      err_count <= err_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_count <= '0;
    end else if (clear_stats) begin
      wrap_count <= '0;
    end else if (wrap_hit && (wrap_count != SAT)) begin
      wrap_count <= wrap_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: behavioural model plus directed
// vectors with hand-computed checkpoints.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cnt_in = 8'd0;
  logic       cnt_en = 1'b0;
  logic       cnt_load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       clear_stats = 1'b0;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic [7:0] wrap_count;
  logic [7:0] expected;

  int checks = 0;
  int errors = 0;

  count_seq_checker #(
    .WIDTH(8),
    .LOCK_CYCLES(4),
    .ERR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cnt_in(cnt_in),
    .cnt_en(cnt_en),
    .cnt_load(cnt_load),
    .load_val(load_val),
    .clear_stats(clear_stats),
    .locked(locked),
    .err(err),
    .err_count(err_count),
    .wrap_count(wrap_count),
    .expected(expected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  // Model: remembers last observation, counts consecutive good predictions.
  int p_cnt = 0;
  int p_lv = 0;
  bit p_en = 0;
  bit p_load = 0;
  bit hv = 0;
  int streak = 0;
  bit m_locked = 0;
  bit m_err = 0;
  int m_errc = 0;
  int m_wrapc = 0;
  int m_exp = 0;
  int m_pred = 0;
  bit m_hit = 0;
  bit mv = 0;

  always @(posedge clk) begin
    mv = 1;
    if (rst) begin
      p_cnt = 0; p_lv = 0; p_en = 0; p_load = 0; hv = 0;
      streak = 0; m_locked = 0; m_err = 0;
      m_errc = 0; m_wrapc = 0; m_exp = 0;
    end else begin
      if (p_load) m_pred = p_lv;
      else if (p_en) m_pred = (p_cnt + 1) % 256;
      else m_pred = p_cnt;
      m_hit = hv && (int'(cnt_in) == m_pred);
      m_err = hv && m_locked && !m_hit;
      if (m_err && m_errc < 255) m_errc++;
      if (m_hit && p_en && !p_load && p_cnt == 255 && m_wrapc < 255)
        m_wrapc++;
      if (clear_stats) begin
        m_errc = 0;
        m_wrapc = 0;
      end
      if (hv) begin
        if (m_hit) begin
          streak++;
          if (streak >= 4) m_locked = 1;
        end else begin
          streak = 0;
          m_locked = 0;
        end
      end
      m_exp = m_pred;
      hv = 1;
      p_cnt = int'(cnt_in);
      p_lv = int'(load_val);
      p_en = cnt_en;
      p_load = cnt_load;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("m_locked", int'(locked), int'(m_locked));
      chk("m_err", int'(err), int'(m_err));
      chk("m_err_count", int'(err_count), m_errc);
      chk("m_wrap_count", int'(wrap_count), m_wrapc);
      chk("m_expected", int'(expected), m_exp);
    end
  end

  task automatic cyc(input int c, input bit en, input bit ld,
                     input int lv, input bit clr);
    cnt_in = c[7:0];
    cnt_en = en;
    cnt_load = ld;
    load_val = lv[7:0];
    clear_stats = clr;
    @(posedge clk);
    #1;
  endtask

  int h;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_wrap_count", int'(wrap_count), 0);
    chk("rst_expected", int'(expected), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cyc(i, 1, 0, 0, 0);
      if (i == 3) chk("lock_early", int'(locked), 0);
    end
    chk("lock_after5", int'(locked), 1);
    chk("lock_err", int'(err), 0);

    cyc(5, 1, 1, 'hFD, 0);
    cyc('hFD, 1, 0, 0, 0);
    cyc('hFE, 1, 0, 0, 0);
    cyc('hFF, 1, 0, 0, 0);
    cyc('h00, 1, 0, 0, 0);
    chk("wrap_count1", int'(wrap_count), 1);
    chk("wrap_noerr", int'(err), 0);
    chk("wrap_exp", int'(expected), 0);

    cyc('h01, 1, 1, 'h5A, 0);
    cyc('h5A, 1, 0, 0, 0);
    chk("load_noerr", int'(err), 0);
    chk("load_locked", int'(locked), 1);
    cyc('h5B, 1, 1, 'h5A, 0);
    cyc('h5B, 0, 0, 0, 0);
    chk("load_err", int'(err), 1);
    chk("load_errc", int'(err_count), 1);
    chk("load_unlock", int'(locked), 0);
    chk("load_exp", int'(expected), 'h5A);
    for (int i = 0; i < 4; i++) begin
      cyc('h5B, 0, 0, 0, 0);
      if (i == 2) chk("relock_early", int'(locked), 0);
    end
    chk("relock", int'(locked), 1);

    cyc('h5B, 0, 1, 'h33, 0);
    repeat (10) cyc('h33, 0, 0, 0, 0);
    chk("hold_noerr", int'(err), 0);
    chk("hold_locked", int'(locked), 1);
    cyc('h34, 0, 0, 0, 0);
    chk("hold_err", int'(err), 1);
    chk("hold_errc", int'(err_count), 2);
    cyc('h34, 0, 0, 0, 0);
    chk("hold_err_pulse", int'(err), 0);

    h = 'h34;
    for (int i = 0; i < 300; i++) begin
      repeat (4) cyc(h, 0, 0, 0, 0);
      h = (h + 1) % 256;
      cyc(h, 0, 0, 0, 0);
    end
    chk("sat_errc", int'(err_count), 255);
    repeat (4) cyc(h, 0, 0, 0, 0);
    h = (h + 1) % 256;
    cyc(h, 0, 0, 0, 1);
    chk("clr_err", int'(err), 1);
    chk("clr_errc", int'(err_count), 0);
    chk("clr_wrapc", int'(wrap_count), 0);

    repeat (4) cyc(h, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      h = (h + 1) % 256;
      cyc(h, 0, 0, 0, 0);
      repeat (4) cyc(h, 0, 0, 0, 0);
    end
    chk("pre_rst_errc", int'(err_count), 3);
    chk("pre_rst_locked", int'(locked), 1);
    rst = 1'b1;
    h = (h + 1) % 256;
    cyc(h, 1, 0, 0, 1);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_errc", int'(err_count), 0);
    chk("mid_rst_exp", int'(expected), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(i + 7, 1, 0, 0, 0);
      if (i == 3) chk("rst_relock_early", int'(locked), 0);
    end
    chk("rst_relock", int'(locked), 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
